// File: rtl/sub_bytes_engine.sv
// Folded AES SubBytes / InvSubBytes engine: LANES S-box pairs sweep a 128-bit state chunk by chunk.
// Optional macro SUB_BYTES_BLK_CNT_EN adds a 32-bit count of delivered blocks (blk_count).

package sub_bytes_pkg;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero as AES requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

endpackage

module Sbox (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);
   import sub_bytes_pkg::*;
   logic [7:0] b;
   assign b = gf_inv(byte_in);
   assign byte_out = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
endmodule

module Inv_Sbox (
   input  logic [7:0] byte_in,
   output logic [7:0] byte_out
);
   import sub_bytes_pkg::*;
   logic [7:0] b;
   assign b = rotl8(byte_in, 1) ^ rotl8(byte_in, 3) ^ rotl8(byte_in, 6) ^ 8'h05;
   assign byte_out = gf_inv(b);
endmodule

module sub_bytes_engine #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
`ifdef SUB_BYTES_BLK_CNT_EN
   ,
   output logic [31:0]  blk_count
`endif
);

   localparam int STEPS = 16 / LANES;
   localparam logic [3:0] LAST_CHUNK = 4'(STEPS - 1);

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       fsm_q, fsm_d;
   logic [127:0] blk_state;
   logic [127:0] blk_next;
   logic         mode;
   logic [3:0]   chunk;

   logic [LANES-1:0][3:0] lane_idx;
   logic [LANES-1:0][7:0] lane_in;
   logic [LANES-1:0][7:0] lane_out;

   // Byte 0 sits in the MSBs, so byte k lives at bit offset (15-k)*8.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] fwd_byte;
      logic [7:0] inv_byte;
      assign lane_idx[l] = 4'(int'(chunk) * LANES + l);
      assign lane_in[l]  = blk_state[{4'd15 - lane_idx[l], 3'b000} +: 8];
      Sbox     u_fwd (.byte_in(lane_in[l]), .byte_out(fwd_byte));
      Inv_Sbox u_inv (.byte_in(lane_in[l]), .byte_out(inv_byte));
      assign lane_out[l] = mode ? inv_byte : fwd_byte;
   end

   always_comb begin
      blk_next = blk_state;
      for (int l = 0; l < LANES; l++) begin
         blk_next[{4'd15 - lane_idx[l], 3'b000} +: 8] = lane_out[l];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fsm_q <= IDLE;
      else     fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d     = fsm_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (fsm_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_d = RUN;
         end
         RUN: begin
            if (chunk == LAST_CHUNK) fsm_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // out_data is a separate register so it survives the next block's acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_state <= '0;
         mode      <= 1'b0;
         chunk     <= '0;
         out_data  <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid) begin
                  blk_state <= in_data;
                  mode      <= in_inv;
                  chunk     <= '0;
               end
            end
            RUN: begin
               blk_state <= blk_next;
               chunk     <= chunk + 4'd1;
               if (chunk == LAST_CHUNK) out_data <= blk_next;
            end
            default: ;
         endcase
      end
   end

`ifdef SUB_BYTES_BLK_CNT_EN
   logic [31:0] blk_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         blk_count_q <= '0;
      else if (out_valid && out_ready) blk_count_q <= blk_count_q + 32'd1;
   end

   assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: random and directed blocks checked against a table-driven AES S-box model.
// Define SUB_BYTES_BLK_CNT_EN at build time to also exercise blk_count.

module tb_sub_bytes_engine;

   localparam int LANES = 4;
   localparam int STEPS = 16 / LANES;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_inv;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
`ifdef SUB_BYTES_BLK_CNT_EN
   logic [31:0]  blk_count;
`endif

   int checks = 0;
   int fails  = 0;
   int cycle  = 0;
   logic [127:0] sb_q[$];
   logic [7:0]   fwd_tab[256];
   logic [7:0]   inv_tab[256];

   sub_bytes_engine #(.LANES(LANES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SUB_BYTES_BLK_CNT_EN
      ,
      .blk_count (blk_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   function automatic logic [7:0] rl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // Builds the S-box by walking the multiplicative group with generator 3.
   function automatic void build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         fwd_tab[p] = x ^ 8'h63;
      end while (p != 8'h01);
      fwd_tab[0] = 8'h63;
      for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] data, input logic inv);
      logic [127:0] r;
      logic [7:0]   b;
      for (int k = 0; k < 16; k++) begin
         b = data[127 - 8 * k -: 8];
         r[127 - 8 * k -: 8] = inv ? inv_tab[b] : fwd_tab[b];
      end
      return r;
   endfunction

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: got timeout, expected DUT response", name);
   endtask

   task automatic apply_stimulus(input logic [127:0] data, input logic inv, output int accept_cycle);
      int budget;
      in_valid = 1'b1;
      in_data  = data;
      in_inv   = inv;
      budget   = 0;
      @(negedge clk);
      while (!in_ready && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) timeout_fail("accept_timeout");
      accept_cycle = cycle + 1;
      sb_q.push_back(ref_sub(data, inv));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom);
   endtask

   task automatic wait_output(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 100);
      if (!out_valid) timeout_fail("output_timeout");
   endtask

   task automatic wait_drain();
      int budget;
      budget = 0;
      while (sb_q.size() != 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (sb_q.size() != 0) timeout_fail("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output handshake pops one expected block.
   initial begin
      logic [127:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
            end else begin
               exp = sb_q.pop_front();
               check_output("scoreboard", out_data, exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t0, t1, t2, n;
      logic [127:0] exp;
      logic [127:0] fwd_vec;
      logic [127:0] inv_vec;
      logic         done;
`ifdef SUB_BYTES_BLK_CNT_EN
      logic [31:0]  cnt0;
`endif
      fwd_vec   = 128'h00102030405060708090a0b0c0d0e0f0;
      inv_vec   = 128'h63cab7040953d051cd60e0e7ba70e18c;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_inv    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      build_tables();

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_in_ready", 128'(in_ready), 128'd1);
      check_output("reset_out_valid", 128'(out_valid), 128'd0);
      check_output("reset_out_data", out_data, 128'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Forward known-answer vector with latency measurement.
      apply_stimulus(fwd_vec, 1'b0, t0);
      wait_output(n);
      check_output("latency_fwd", 128'(n), 128'(STEPS));
      check_output("fwd_vector", out_data, inv_vec);
      out_ready = 1'b1;
      wait_drain();
      check_output("out_valid_drops", 128'(out_valid), 128'd0);

      // Inverse known-answer vector.
      apply_stimulus(inv_vec, 1'b1, t0);
      wait_output(n);
      check_output("latency_inv", 128'(n), 128'(STEPS));
      check_output("inv_vector", out_data, fwd_vec);
      wait_drain();

      // Back-pressure: result must stay put while inputs wiggle.
      out_ready = 1'b0;
      exp = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus(exp, 1'b0, t0);
      exp = ref_sub(exp, 1'b0);
      wait_output(n);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         in_inv   = 1'($urandom);
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check_output("bp_out_valid", 128'(out_valid), 128'd1);
         check_output("bp_in_ready", 128'(in_ready), 128'd0);
         check_output("bp_out_data", out_data, exp);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Asynchronous reset two chunks into a block.
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, t0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_output("rst_out_valid", 128'(out_valid), 128'd0);
      check_output("rst_in_ready", 128'(in_ready), 128'd1);
      check_output("rst_out_data", out_data, 128'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply_stimulus(128'd0, 1'b0, t0);
      wait_output(n);
      check_output("post_rst_zero", out_data, {16{8'h63}});
      wait_drain();

      // Back-to-back blocks: one acceptance every STEPS+2 cycles.
`ifdef SUB_BYTES_BLK_CNT_EN
      cnt0 = blk_count;
`endif
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), t0);
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), t1);
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), t2);
      check_output("throughput_1", 128'(t1 - t0), 128'(STEPS + 2));
      check_output("throughput_2", 128'(t2 - t1), 128'(STEPS + 2));
      wait_drain();
`ifdef SUB_BYTES_BLK_CNT_EN
      check_output("blk_count_3", 128'(blk_count), 128'(cnt0 + 32'd3));
      force dut.blk_count_q = 32'hffff_ffff;
      @(posedge clk);
      #1;
      release dut.blk_count_q;
      apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, t0);
      wait_drain();
      check_output("blk_count_wrap", 128'(blk_count), 128'd0);
`endif

      // Random traffic with random downstream stalls.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               apply_stimulus({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), t0);
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      check_output("scoreboard_empty", 128'(sb_q.size()), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
